// File: rtl/output_layer_if.sv
// AXI4 master bus bundle for output_layer: full write channel set plus the
// unused read channel, with master/slave views.
interface output_layer_if #(
  parameter int ID_W   = 1,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/output_layer.sv
// Packs raster-order 8-bit pixels into little-endian AXI words and writes each
// row to DDR as INCR bursts, one outstanding transaction at a time.
//
// state  | meaning
// IDLE   | waiting for Start
// AW     | current burst's words are buffering; address offered once all present
// W      | streaming the burst's beats out of the word FIFO
// B      | waiting for the write response
// DONE   | done pulse (held one extra cycle for an empty frame)
module output_layer #(
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 64,
  parameter int C_M_AXI_BURST_LEN  = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          Start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] axi_address,
  input  logic [15:0]                   allocated_space_per_row,
  input  logic [15:0]                   output_layer_row_size,
  input  logic [15:0]                   output_layer_col_size,
  input  logic [7:0]                    output_layer_data,
  input  logic                          output_layer_valid,
  output logic                          output_layer_rdy,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output_layer_if.master                m_axi
);
  localparam int AW     = C_M_AXI_ADDR_WIDTH;
  localparam int DW     = C_M_AXI_DATA_WIDTH;
  localparam int BYTES  = DW / 8;
  localparam int LANE_W = $clog2(BYTES);
  localparam int BL     = C_M_AXI_BURST_LEN;
  localparam int LOG_BL = $clog2(BL);
  localparam int DEPTH  = 2 * BL;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam logic [AW-1:0] BURST_BYTES = AW'(BL * BYTES);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AW   = 3'd1;
  localparam logic [2:0] S_W    = 3'd2;
  localparam logic [2:0] S_B    = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state;
  logic              zero_hold;
  logic              busy_q, error_q;
  logic [15:0]       row_size_q, col_size_q, pitch_q;
  logic [16:0]       full_q, rem_q, bursts_q, burst_idx;
  logic [15:0]       row_idx;
  logic [AW-1:0]     row_base, awaddr_q;
  logic [7:0]        awlen_q, beat;

  logic [31:0]       pix_left;
  logic [15:0]       byte_pos;
  logic [DW-1:0]     acc_data, new_data;
  logic [BYTES-1:0]  acc_strb, new_strb;
  logic [LANE_W-1:0] lane;
  logic              row_end, word_end, accept, push, pop;

  logic [DW-1:0]     fifo_data [DEPTH];
  logic [BYTES-1:0]  fifo_strb [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              fifo_full;

  logic [16:0]       words_in, full_in, rem_in;
  logic              start_go, size_zero, b_hs, more_bursts, more_rows;

  function automatic logic [7:0] awlen_for(input logic [16:0] idx,
                                           input logic [16:0] fulls,
                                           input logic [16:0] rem);
    logic [16:0] n;
    n = (idx < fulls) ? 17'(BL) : rem;
    return 8'(n - 17'd1);
  endfunction

  assign words_in    = ({1'b0, output_layer_row_size} + 17'(BYTES - 1)) >> LANE_W;
  assign full_in     = words_in >> LOG_BL;
  assign rem_in      = words_in & 17'(BL - 1);
  assign start_go    = Start & (state == S_IDLE);
  assign size_zero   = (output_layer_row_size == 16'd0) | (output_layer_col_size == 16'd0);
  assign b_hs        = (state == S_B) & m_axi.bvalid;
  assign more_bursts = (burst_idx + 17'd1) < bursts_q;
  assign more_rows   = (17'(row_idx) + 17'd1) < {1'b0, col_size_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      zero_hold  <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
      row_size_q <= '0;
      col_size_q <= '0;
      pitch_q    <= '0;
      full_q     <= '0;
      rem_q      <= '0;
      bursts_q   <= '0;
      burst_idx  <= '0;
      row_idx    <= '0;
      row_base   <= '0;
      awaddr_q   <= '0;
      awlen_q    <= '0;
      beat       <= '0;
    end else begin
      case (state)
        S_IDLE: if (start_go) begin
          busy_q     <= 1'b1;
          error_q    <= 1'b0;
          row_size_q <= output_layer_row_size;
          col_size_q <= output_layer_col_size;
          pitch_q    <= allocated_space_per_row;
          full_q     <= full_in;
          rem_q      <= rem_in;
          bursts_q   <= full_in + {16'd0, rem_in != 17'd0};
          burst_idx  <= '0;
          row_idx    <= '0;
          row_base   <= axi_address;
          awaddr_q   <= axi_address;
          awlen_q    <= awlen_for(17'd0, full_in, rem_in);
          if (size_zero) begin
            state     <= S_DONE;
            zero_hold <= 1'b1;
          end else begin
            state <= S_AW;
          end
        end
        S_AW: if (m_axi.awvalid && m_axi.awready) begin
          state <= S_W;
          beat  <= '0;
        end
        S_W: if (m_axi.wvalid && m_axi.wready) begin
          beat <= beat + 8'd1;
          if (m_axi.wlast) state <= S_B;
        end
        S_B: if (b_hs) begin
          error_q <= error_q | (m_axi.bresp != 2'b00);
          if (more_bursts) begin
            burst_idx <= burst_idx + 17'd1;
            awaddr_q  <= awaddr_q + BURST_BYTES;
            awlen_q   <= awlen_for(burst_idx + 17'd1, full_q, rem_q);
            state     <= S_AW;
          end else if (more_rows) begin
            row_idx   <= row_idx + 16'd1;
            row_base  <= row_base + AW'(pitch_q);
            awaddr_q  <= row_base + AW'(pitch_q);
            burst_idx <= '0;
            awlen_q   <= awlen_for(17'd0, full_q, rem_q);
            state     <= S_AW;
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (zero_hold) begin
            zero_hold <= 1'b0;
          end else begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Packer: byte k of a row lands in lane k mod BYTES of word k/BYTES.
  assign lane      = byte_pos[LANE_W-1:0];
  assign row_end   = byte_pos == (row_size_q - 16'd1);
  assign word_end  = (lane == {LANE_W{1'b1}}) | row_end;
  assign new_data  = acc_data | (DW'(output_layer_data) << {lane, 3'b000});
  assign new_strb  = acc_strb | (BYTES'(1) << lane);
  assign accept    = output_layer_valid & output_layer_rdy;
  assign push      = accept & word_end;
  assign pop       = m_axi.wvalid & m_axi.wready;
  assign fifo_full = count == (PTR_W + 1)'(DEPTH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_left <= '0;
      byte_pos <= '0;
      acc_data <= '0;
      acc_strb <= '0;
    end else if (start_go) begin
      pix_left <= 32'(output_layer_row_size) * 32'(output_layer_col_size);
      byte_pos <= '0;
      acc_data <= '0;
      acc_strb <= '0;
    end else if (accept) begin
      pix_left <= pix_left - 32'd1;
      byte_pos <= row_end ? 16'd0 : byte_pos + 16'd1;
      acc_data <= word_end ? '0 : new_data;
      acc_strb <= word_end ? '0 : new_strb;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= new_data;
      fifo_strb[wr_ptr] <= new_strb;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign output_layer_rdy = busy_q & ~fifo_full & (pix_left != 32'd0);
  assign busy             = busy_q;
  assign done             = (state == S_DONE) & ~zero_hold;
  assign error            = error_q;

  // Address is held back until the whole burst is buffered so W never stalls.
  assign m_axi.awvalid = (state == S_AW) & (9'(count) > {1'b0, awlen_q});
  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awlen   = awlen_q;
  assign m_axi.awid    = '0;
  assign m_axi.awsize  = 3'd3;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'b0011;
  assign m_axi.awprot  = 3'd0;
  assign m_axi.awqos   = 4'd0;
  assign m_axi.wvalid  = (state == S_W);
  assign m_axi.wdata   = m_axi.wvalid ? fifo_data[rd_ptr] : '0;
  assign m_axi.wstrb   = m_axi.wvalid ? fifo_strb[rd_ptr] : '0;
  assign m_axi.wlast   = m_axi.wvalid & (beat == awlen_q);
  assign m_axi.bready  = (state == S_B);
  assign m_axi.arid    = '0;
  assign m_axi.araddr  = '0;
  assign m_axi.arlen   = '0;
  assign m_axi.arsize  = '0;
  assign m_axi.arburst = '0;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = '0;
  assign m_axi.arprot  = '0;
  assign m_axi.arqos   = '0;
  assign m_axi.arvalid = 1'b0;
  assign m_axi.rready  = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{m_axi.bid, m_axi.arready, m_axi.rid, m_axi.rdata,
                           m_axi.rresp, m_axi.rlast, m_axi.rvalid};
endmodule

// File: tb/tb_output_layer.sv
// Scoreboard bench for output_layer: a stallable AXI slave model with a byte
// memory, a queue-based AW/W checker, and directed frame scenarios.
module tb_output_layer;
  localparam int BL = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        lst;
  } w_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] axi_address;
  logic [15:0] pitch, row_size, col_size;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_rdy, busy, done, error;

  output_layer_if #(.ID_W(1), .ADDR_W(32), .DATA_W(64)) bus ();

  output_layer #(
    .C_M_AXI_ID_WIDTH(1), .C_M_AXI_ADDR_WIDTH(32),
    .C_M_AXI_DATA_WIDTH(64), .C_M_AXI_BURST_LEN(BL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .Start(start), .axi_address(axi_address),
    .allocated_space_per_row(pitch), .output_layer_row_size(row_size),
    .output_layer_col_size(col_size), .output_layer_data(pix_data),
    .output_layer_valid(pix_valid), .output_layer_rdy(pix_rdy),
    .busy(busy), .done(done), .error(error), .m_axi(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  bit rnd_mode = 0;
  bit err_next = 0;
  bit abort = 0;

  aw_t exp_aw[$];
  w_t  exp_w[$];
  logic [7:0]  mem [int unsigned];
  logic [7:0]  exp_mem [int unsigned];
  logic [31:0] aw_log[$];
  logic [7:0]  awlen_log[$];
  logic [63:0] w_log[$];
  logic [7:0]  wstrb_log[$];
  logic        wlast_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops expected AW/W entries on every handshake.
  bit in_burst = 0;
  bit drop_seen = 0;
  initial begin
    aw_t a;
    w_t  w;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_burst = 0;
        drop_seen = 0;
      end else begin
        if (done) done_cnt++;
        if (in_burst && !bus.wvalid) drop_seen = 1;
        if (bus.awvalid && bus.awready) begin
          if (exp_aw.size() == 0) check("aw_unexpected", {32'd0, bus.awaddr}, 64'hFFFF_FFFF);
          else begin
            a = exp_aw.pop_front();
            check("aw_addr", {32'd0, bus.awaddr}, {32'd0, a.addr});
            check("aw_len", {56'd0, bus.awlen}, {56'd0, a.len});
          end
        end
        if (bus.wvalid && bus.wready) begin
          if (exp_w.size() == 0) check("w_unexpected", bus.wdata, 64'hFFFF_FFFF_FFFF_FFFF);
          else begin
            w = exp_w.pop_front();
            check("w_data", bus.wdata, w.data);
            check("w_strb", {56'd0, bus.wstrb}, {56'd0, w.strb});
            check("w_last", {63'd0, bus.wlast}, {63'd0, w.lst});
          end
          if (bus.wlast) begin
            check("wvalid_held", {63'd0, drop_seen}, 64'd0);
            in_burst = 0;
            drop_seen = 0;
          end else begin
            in_burst = 1;
          end
        end
      end
    end
  end

  // AXI slave model with optional random stalls.
  initial begin
    int unsigned cur_addr;
    int beat;
    int b_pending;
    bit b_hs, b_err_hs;
    cur_addr = 0; beat = 0; b_pending = 0; b_hs = 0; b_err_hs = 0;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0; bus.bid = '0;
    bus.arready = 0; bus.rid = '0; bus.rdata = '0; bus.rresp = 0; bus.rlast = 0; bus.rvalid = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        b_pending = 0; beat = 0; b_hs = 0; b_err_hs = 0;
      end else begin
        if (bus.awvalid && bus.awready) begin
          cur_addr = bus.awaddr;
          beat = 0;
          aw_log.push_back(bus.awaddr);
          awlen_log.push_back(bus.awlen);
        end
        if (bus.wvalid && bus.wready) begin
          for (int i = 0; i < 8; i++)
            if (bus.wstrb[i]) mem[cur_addr + 32'(beat * 8 + i)] = bus.wdata[8*i +: 8];
          w_log.push_back(bus.wdata);
          wstrb_log.push_back(bus.wstrb);
          wlast_log.push_back(bus.wlast);
          beat++;
          if (bus.wlast) b_pending++;
        end
        if (bus.bvalid && bus.bready) begin
          b_pending--;
          b_hs = 1;
          b_err_hs = (bus.bresp != 2'b00);
        end
      end
      @(posedge clk);
      #1;
      if (b_err_hs) check("error_after_bresp", {63'd0, error}, 64'd1);
      b_err_hs = 0;
      bus.awready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.wready  = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!reset_n) begin
        bus.bvalid = 0;
        bus.bresp = 0;
      end else if (b_hs || !bus.bvalid) begin
        if (b_pending > 0 && (!rnd_mode || $urandom_range(0, 1) == 1)) begin
          bus.bvalid = 1;
          bus.bresp = err_next ? 2'b10 : 2'b00;
          err_next = 0;
        end else begin
          bus.bvalid = 0;
          bus.bresp = 0;
        end
      end
      b_hs = 0;
    end
  end

  task automatic build_expected(input int base, input int pt, input int row, input int col);
    int words, k, nb;
    aw_t a;
    w_t  e;
    logic [7:0] p;
    words = (row + 7) / 8;
    for (int r = 0; r < col; r++) begin
      for (int w = 0; w < words; w++) begin
        e = '0;
        for (int l = 0; l < 8; l++) begin
          k = w * 8 + l;
          if (k < row) begin
            p = 8'(r * row + k);
            e.data[8*l +: 8] = p;
            e.strb[l] = 1'b1;
            exp_mem[32'(base + r * pt + k)] = p;
          end
        end
        e.lst = (w % BL == BL - 1) || (w == words - 1);
        if (w % BL == 0) begin
          nb = (words - w >= BL) ? BL : words - w;
          a.addr = 32'(base + r * pt + w * 8);
          a.len = 8'(nb - 1);
          exp_aw.push_back(a);
        end
        exp_w.push_back(e);
      end
    end
  endtask

  task automatic start_frame(input int base, input int pt, input int row, input int col);
    @(posedge clk); #1;
    axi_address = 32'(base); pitch = 16'(pt); row_size = 16'(row); col_size = 16'(col);
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic drive_pixels(input int total, input bit rnd);
    int k, cyc;
    k = 0; cyc = 0;
    while (k < total && !abort && cyc < 20000) begin
      pix_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_data = 8'(k);
      @(negedge clk);
      if (pix_valid && pix_rdy) k++;
      @(posedge clk); #1;
      cyc++;
    end
    pix_valid = 0;
    if (!abort) check("pixels_accepted", 64'(k), 64'(total));
  endtask

  task automatic clear_logs();
    mem.delete(); exp_mem.delete();
    aw_log.delete(); awlen_log.delete(); w_log.delete(); wstrb_log.delete(); wlast_log.delete();
  endtask

  task automatic run_frame(input int base, input int pt, input int row, input int col,
                           input bit rnd, input bit err);
    int d0, cyc, bad;
    clear_logs();
    build_expected(base, pt, row, col);
    rnd_mode = rnd;
    err_next = err;
    d0 = done_cnt;
    start_frame(base, pt, row, col);
    check("busy_after_start", {63'd0, busy}, 64'd1);
    check("error_cleared_by_start", {63'd0, error}, 64'd0);
    drive_pixels(row * col, rnd);
    cyc = 0;
    while (done_cnt == d0 && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    check("done_once", 64'(done_cnt - d0), 64'd1);
    check("busy_after_done", {63'd0, busy}, 64'd0);
    check("error_flag", {63'd0, error}, {63'd0, err});
    check("aw_remaining", 64'(exp_aw.size()), 64'd0);
    check("w_remaining", 64'(exp_w.size()), 64'd0);
    bad = 0;
    foreach (exp_mem[a]) if (!mem.exists(a) || mem[a] !== exp_mem[a]) bad++;
    check("mem_image_bytes", 64'(bad), 64'd0);
    check("mem_image_size", 64'(mem.num()), 64'(exp_mem.num()));
    rnd_mode = 0;
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_awvalid"}, {63'd0, bus.awvalid}, 64'd0);
    check({pfx, "_wvalid"},  {63'd0, bus.wvalid}, 64'd0);
    check({pfx, "_wlast"},   {63'd0, bus.wlast}, 64'd0);
    check({pfx, "_bready"},  {63'd0, bus.bready}, 64'd0);
    check({pfx, "_rdy"},     {63'd0, pix_rdy}, 64'd0);
    check({pfx, "_busy"},    {63'd0, busy}, 64'd0);
    check({pfx, "_done"},    {63'd0, done}, 64'd0);
    check({pfx, "_error"},   {63'd0, error}, 64'd0);
    check({pfx, "_awaddr"},  {32'd0, bus.awaddr}, 64'd0);
    check({pfx, "_awlen"},   {56'd0, bus.awlen}, 64'd0);
    check({pfx, "_wdata"},   bus.wdata, 64'd0);
    check({pfx, "_wstrb"},   {56'd0, bus.wstrb}, 64'd0);
  endtask

  initial begin
    int d0, cyc;
    bit saw_aw, saw_rdy;
    logic [3:0] lasts;
    reset_n = 0; start = 0; pix_valid = 0; pix_data = 0;
    axi_address = 0; pitch = 0; row_size = 0; col_size = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");
    @(negedge clk);
    reset_n = 1;

    // Basic two-row frame
    run_frame(32'h1000, 512, 16, 2, 0, 0);
    check("basic_aw_count", 64'(aw_log.size()), 64'd2);
    if (aw_log.size() == 2) begin
      check("basic_aw0_addr", {32'd0, aw_log[0]}, 64'h1000);
      check("basic_aw0_len", {56'd0, awlen_log[0]}, 64'd1);
      check("basic_aw1_addr", {32'd0, aw_log[1]}, 64'h1200);
      check("basic_aw1_len", {56'd0, awlen_log[1]}, 64'd1);
    end
    check("basic_beat_count", 64'(w_log.size()), 64'd4);
    if (w_log.size() == 4) begin
      check("basic_first_wdata", w_log[0], 64'h0706050403020100);
      check("basic_first_wstrb", {56'd0, wstrb_log[0]}, 64'hFF);
      lasts = {wlast_log[3], wlast_log[2], wlast_log[1], wlast_log[0]};
      check("basic_wlast_beats", {60'd0, lasts}, 64'b1010);
    end

    // Partial last word and short burst
    run_frame(32'h1000, 512, 113, 1, 0, 0);
    check("partial_aw_count", 64'(aw_log.size()), 64'd2);
    if (aw_log.size() == 2) begin
      check("partial_aw0_addr", {32'd0, aw_log[0]}, 64'h1000);
      check("partial_aw0_len", {56'd0, awlen_log[0]}, 64'd7);
      check("partial_aw1_addr", {32'd0, aw_log[1]}, 64'h1040);
      check("partial_aw1_len", {56'd0, awlen_log[1]}, 64'd6);
    end
    if (w_log.size() > 0) begin
      check("partial_last_wdata", w_log[w_log.size() - 1], 64'h70);
      check("partial_last_wstrb", {56'd0, wstrb_log[wstrb_log.size() - 1]}, 64'h01);
    end

    // Backpressure on every channel
    run_frame(32'h1000, 512, 16, 2, 1, 0);

    // Error response on first burst, then cleared by a new Start
    run_frame(32'h1000, 512, 16, 2, 0, 1);
    run_frame(32'h1000, 512, 16, 2, 0, 0);

    // Zero-size frame
    clear_logs();
    d0 = done_cnt;
    saw_aw = 0; saw_rdy = 0;
    start_frame(32'h2000, 512, 0, 5);
    @(negedge clk);
    saw_aw |= bus.awvalid; saw_rdy |= pix_rdy;
    check("zero_done_c1", {63'd0, done}, 64'd0);
    @(negedge clk);
    saw_aw |= bus.awvalid; saw_rdy |= pix_rdy;
    check("zero_done_c2", {63'd0, done}, 64'd1);
    @(negedge clk);
    saw_aw |= bus.awvalid; saw_rdy |= pix_rdy;
    check("zero_done_c3", {63'd0, done}, 64'd0);
    check("zero_busy_end", {63'd0, busy}, 64'd0);
    check("zero_no_awvalid", {63'd0, saw_aw}, 64'd0);
    check("zero_no_rdy", {63'd0, saw_rdy}, 64'd0);
    check("zero_done_count", 64'(done_cnt - d0), 64'd1);

    // Reset during W, then a clean frame
    clear_logs();
    build_expected(32'h1000, 512, 16, 2);
    d0 = done_cnt;
    start_frame(32'h1000, 512, 16, 2);
    fork
      drive_pixels(32, 0);
      begin
        cyc = 0;
        do begin
          @(negedge clk);
          cyc++;
        end while (!bus.wvalid && cyc < 2000);
        check("midrst_reached_w", {63'd0, bus.wvalid}, 64'd1);
        reset_n = 0;
        #1;
        check_reset("midrst");
        abort = 1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    exp_aw.delete();
    exp_w.delete();
    check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    abort = 0;
    reset_n = 1;
    run_frame(32'h1000, 512, 16, 2, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
